charge_ctrl_multi: RTL and testbench

- Parametrised successor to the single-point coin-operated charging FSM; serves NUM_CH charging points from one keypad and one pair of 2-digit BCD displays.
- Front-end FSM handles power-up, money entry, clear and confirm. Per-channel countdown timers run independently, so one channel can be charging while another is being set up.
- Sits between the keypad scanner (key strobe plus code) and the 7-segment display driver.

---
 rtl/charge_pkg.sv | 30 +++
 rtl/charge_ctrl_multi_if.sv | 30 +++
 rtl/charge_timer.sv | 38 +++
 rtl/charge_ctrl_multi.sv | 203 ++++++++++++++++++++
 tb/tb_charge_ctrl_multi.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/charge_pkg.sv
// Shared definitions for the multi-channel coin-operated charging controller:
// keypad codes, front-end FSM state names and the binary-to-BCD helper.
// Latency: n/a (package only). Backpressure: n/a.
package charge_pkg;

  // Keypad codes above the ten digits; 13..15 carry no meaning.
  localparam logic [3:0] KEY_START   = 4'd10;
  localparam logic [3:0] KEY_CLEAR   = 4'd11;
  localparam logic [3:0] KEY_CONFIRM = 4'd12;

  // Front-end FSM states.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    READY = 2'd1,
    ENTRY = 2'd2
  } state_e;

  // Display code that the 7-segment driver renders as blank.
  localparam logic [7:0] BCD_BLANK = 8'hFF;

  // Two-digit BCD of a value in 0..99: tens in [7:4], ones in [3:0].
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/charge_ctrl_multi_if.sv
// Keypad / display / status bundle between the keypad scanner, the charging
// controller and the 7-segment driver. Latency: n/a (wires only).
// Backpressure: none; KeyValid is a one-cycle strobe that is never stalled.
//   master: keypad side (drives KeyValid/KeyCode/ChSel, observes outputs)
//   slave : controller side (consumes keys, drives displays and status)
interface charge_ctrl_multi_if #(
  parameter int NUM_CH = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              KeyValid;
  logic [3:0]        KeyCode;
  logic [CH_W-1:0]   ChSel;
  logic [7:0]        NumMoney;
  logic [7:0]        NumTime;
  logic [NUM_CH-1:0] Charging;
  logic [NUM_CH-1:0] ChDone;
  logic              Err;

  modport master (
    output KeyValid, KeyCode, ChSel,
    input  NumMoney, NumTime, Charging, ChDone, Err
  );

  modport slave (
    input  KeyValid, KeyCode, ChSel,
    output NumMoney, NumTime, Charging, ChDone, Err
  );

endinterface

// File: rtl/charge_timer.sv
// Per-channel charge countdown in whole seconds.
// Latency: active/remaining follow load by one cycle; done pulses on the expiring tick.
// Backpressure: none; load and tick are accepted every cycle, load takes priority.
//   Ports: Clk1, Rst (sync, active high), load, load_val[6:0], tick,
//          remaining[6:0], active, done
module charge_timer (
  input  logic       Clk1,
  input  logic       Rst,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       tick,
  output logic [6:0] remaining,
  output logic       active,
  output logic       done
);

  always_ff @(posedge Clk1) begin
    if (Rst) begin
      remaining <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // A tick coinciding with the load is swallowed so the full time is served.
        remaining <= load_val;
        active    <= (load_val != 7'd0);
      end else if (active && tick) begin
        remaining <= remaining - 7'd1;
        if (remaining == 7'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/charge_ctrl_multi.sv
// Multi-channel charging controller: one keypad front end, NUM_CH independent timers.
// Latency: state/timers update one cycle after a key; displays lag the state by one more cycle.
// Backpressure: none; every key strobe is consumed or ignored in the cycle it arrives.
//   Ports: Clk1, Rst (sync, active high), bus (slave): KeyValid, KeyCode, ChSel in;
//          NumMoney, NumTime, Charging[NUM_CH], ChDone[NUM_CH], Err out.
module charge_ctrl_multi
  import charge_pkg::*;
#(
  parameter int TICK_DIV  = 500,
  parameter int NUM_CH    = 2,
  parameter int RATE      = 2,
  parameter int MAX_MONEY = 20,
  parameter int IDLE_SEC  = 10
) (
  input logic                Clk1,
  input logic                Rst,
  charge_ctrl_multi_if.slave bus
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int IDLE_W = $clog2(IDLE_SEC + 1);

  localparam logic [1:0] S_OFF   = OFF;
  localparam logic [1:0] S_READY = READY;
  localparam logic [1:0] S_ENTRY = ENTRY;

  localparam logic [6:0]        MAX_M    = 7'(MAX_MONEY);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_SEC - 1);

  // ---------------------------------------------------------------------------
  // 1 s tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge Clk1) begin
    if (Rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Front-end FSM
  // ---------------------------------------------------------------------------
  logic [1:0]        state, state_n;
  logic [6:0]        money, money_n;
  logic              second, second_n;     // second digit already taken
  logic [CH_W-1:0]   ent_ch, ent_ch_n;
  logic [CH_W-1:0]   sel_ch;
  logic [IDLE_W-1:0] idle, idle_n;
  logic              err, err_n;
  logic [NUM_CH-1:0] load_vec;
  logic [NUM_CH-1:0] active_vec;
  logic [NUM_CH-1:0] done_vec;
  logic [6:0]        load_val;
  logic [6:0]        rem [NUM_CH];
  logic              is_digit;
  logic [6:0]        first_val;
  logic [7:0]        combined;

  // A selector pointing past the last channel falls back to channel 0.
  assign sel_ch = (int'(bus.ChSel) < NUM_CH) ? bus.ChSel : '0;

  assign is_digit  = (bus.KeyCode <= 4'd9);
  assign first_val = ({3'b0, bus.KeyCode} > MAX_M) ? MAX_M : {3'b0, bus.KeyCode};
  // money <= 9 when the second digit arrives, so 10*money+d stays within 8 bits.
  assign combined  = {1'b0, money} * 8'd10 + {4'd0, bus.KeyCode};
  assign load_val  = 7'(money * RATE);

  always_comb begin
    state_n  = state;
    money_n  = money;
    second_n = second;
    ent_ch_n = ent_ch;
    idle_n   = idle;
    err_n    = 1'b0;
    load_vec = '0;

    // Idle timeout only runs in READY with nothing charging; any key restarts it.
    // A key in the timeout cycle suppresses the timeout, so the key always wins.
    if (bus.KeyValid) begin
      idle_n = '0;
    end else if (state == S_READY && active_vec == '0) begin
      if (tick) begin
        if (idle == IDLE_END) begin
          idle_n  = '0;
          state_n = S_OFF;
        end else begin
          idle_n = idle + IDLE_W'(1);
        end
      end
    end else begin
      idle_n = '0;
    end

    if (bus.KeyValid) begin
      case (state)
        S_OFF: begin
          if (bus.KeyCode == KEY_START) state_n = S_READY;
        end
        S_READY: begin
          if (is_digit) begin
            state_n  = S_ENTRY;
            money_n  = first_val;
            second_n = 1'b0;
            ent_ch_n = sel_ch;
          end
        end
        S_ENTRY: begin
          if (is_digit) begin
            if (!second && money != MAX_M) begin
              money_n  = (combined > {1'b0, MAX_M}) ? MAX_M : combined[6:0];
              second_n = 1'b1;
            end
          end else if (bus.KeyCode == KEY_CLEAR) begin
            money_n = '0;
            state_n = S_READY;
          end else if (bus.KeyCode == KEY_CONFIRM && money != 7'd0) begin
            // A busy channel rejects the purchase; the money is dropped either way.
            if (active_vec[ent_ch]) err_n = 1'b1;
            else                    load_vec[ent_ch] = 1'b1;
            money_n = '0;
            state_n = S_READY;
          end
        end
        default: state_n = S_OFF;
      endcase
    end
  end

  always_ff @(posedge Clk1) begin
    if (Rst) begin
      state  <= S_OFF;
      money  <= '0;
      second <= 1'b0;
      ent_ch <= '0;
      idle   <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      money  <= money_n;
      second <= second_n;
      ent_ch <= ent_ch_n;
      idle   <= idle_n;
      err    <= err_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel timers
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    charge_timer u_timer (
      .Clk1      (Clk1),
      .Rst       (Rst),
      .load      (load_vec[g]),
      .load_val  (load_val),
      .tick      (tick),
      .remaining (rem[g]),
      .active    (active_vec[g]),
      .done      (done_vec[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Display registers, built from the registered state so they follow it by one
  // cycle; the READY view tracks ChSel live, the ENTRY view the latched channel's money.
  // ---------------------------------------------------------------------------
  logic [7:0] num_money, num_time;

  always_ff @(posedge Clk1) begin
    if (Rst) begin
      num_money <= BCD_BLANK;
      num_time  <= BCD_BLANK;
    end else begin
      case (state)
        S_ENTRY: begin
          num_money <= bin2bcd(money);
          num_time  <= bin2bcd(load_val);
        end
        S_READY: begin
          num_money <= 8'h00;
          num_time  <= active_vec[sel_ch] ? bin2bcd(rem[sel_ch]) : 8'h00;
        end
        default: begin
          num_money <= BCD_BLANK;
          num_time  <= BCD_BLANK;
        end
      endcase
    end
  end

  assign bus.NumMoney = num_money;
  assign bus.NumTime  = num_time;
  assign bus.Charging = active_vec;
  assign bus.ChDone   = done_vec;
  assign bus.Err      = err;

endmodule

// File: tb/tb_charge_ctrl_multi.sv
// Self-checking bench for charge_ctrl_multi: directed scenarios plus random keys,
// every cycle compared against a behavioural model of the controller rules.
module tb_charge_ctrl_multi;

  localparam int TICK_DIV  = 4;
  localparam int NUM_CH    = 2;
  localparam int RATE      = 2;
  localparam int MAX_MONEY = 20;
  localparam int IDLE_SEC  = 10;

  logic Clk1 = 1'b0;
  logic Rst  = 1'b1;
  always #5 Clk1 = ~Clk1;

  charge_ctrl_multi_if #(.NUM_CH(NUM_CH)) bus ();

  charge_ctrl_multi #(
    .TICK_DIV (TICK_DIV),
    .NUM_CH   (NUM_CH),
    .RATE     (RATE),
    .MAX_MONEY(MAX_MONEY),
    .IDLE_SEC (IDLE_SEC)
  ) dut (
    .Clk1(Clk1),
    .Rst (Rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = off, 1 = ready, 2 = entry.
  int m_state, m_money, m_ch, m_idle, m_edges, m_nm, m_nt, tick_total;
  bit m_second, m_err, m_tick;
  int m_rem  [NUM_CH];
  bit m_chg  [NUM_CH];
  bit m_done [NUM_CH];
  int cur_sel = 0;

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit v, input int code, input int sel, input bit rst);
    bit any_chg;
    int load_ch, load_amt, nstate, sel_c;
    if (rst) begin
      m_state = 0; m_money = 0; m_ch = 0; m_idle = 0; m_edges = 0;
      m_second = 0; m_err = 0; m_tick = 0; m_nm = 255; m_nt = 255;
      for (int i = 0; i < NUM_CH; i++) begin m_rem[i] = 0; m_chg[i] = 0; m_done[i] = 0; end
      return;
    end
    m_edges++;
    m_tick = (m_edges % TICK_DIV) == 0;
    if (m_tick) tick_total++;
    sel_c = (sel < NUM_CH) ? sel : 0;
    // Displays show the situation as it stood before this edge.
    if (m_state == 0)      begin m_nm = 255; m_nt = 255; end
    else if (m_state == 2) begin m_nm = bcd(m_money); m_nt = bcd(m_money * RATE); end
    else if (m_chg[sel_c]) begin m_nm = 0; m_nt = bcd(m_rem[sel_c]); end
    else                   begin m_nm = 0; m_nt = 0; end
    any_chg = 0;
    for (int i = 0; i < NUM_CH; i++) any_chg |= m_chg[i];
    nstate = m_state; load_ch = -1; load_amt = 0; m_err = 0;
    if (v) m_idle = 0;
    else if (m_state == 1 && !any_chg) begin
      if (m_tick) begin
        m_idle++;
        if (m_idle == IDLE_SEC) begin m_idle = 0; nstate = 0; end
      end
    end else m_idle = 0;
    if (v) begin
      if (m_state == 0) begin
        if (code == 10) nstate = 1;
      end else if (m_state == 1) begin
        if (code <= 9) begin nstate = 2; m_money = min2(code, MAX_MONEY); m_second = 0; m_ch = sel_c; end
      end else begin
        if (code <= 9) begin
          if (!m_second && m_money != MAX_MONEY) begin
            m_money = min2(10 * m_money + code, MAX_MONEY); m_second = 1;
          end
        end else if (code == 11) begin
          m_money = 0; nstate = 1;
        end else if (code == 12 && m_money != 0) begin
          if (m_chg[m_ch]) m_err = 1;
          else begin load_ch = m_ch; load_amt = m_money * RATE; end
          m_money = 0; nstate = 1;
        end
      end
    end
    m_state = nstate;
    for (int i = 0; i < NUM_CH; i++) begin
      m_done[i] = 0;
      if (i == load_ch) begin m_rem[i] = load_amt; m_chg[i] = 1; end
      else if (m_chg[i] && m_tick) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin m_chg[i] = 0; m_done[i] = 1; end
      end
    end
  endtask

  task automatic step(input bit v, input int code, input int sel, input bit rst);
    logic [NUM_CH-1:0] ec, ed;
    Rst = rst;
    bus.KeyValid = v;
    bus.KeyCode  = 4'(code);
    bus.ChSel    = 1'(sel);
    @(posedge Clk1);
    model_step(v, code, sel, rst);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin ec[i] = m_chg[i]; ed[i] = m_done[i]; end
    chk("NumMoney", 32'(bus.NumMoney), m_nm);
    chk("NumTime",  32'(bus.NumTime),  m_nt);
    chk("Charging", 32'(bus.Charging), 32'(ec));
    chk("ChDone",   32'(bus.ChDone),   32'(ed));
    chk("Err",      32'(bus.Err),      32'(m_err));
  endtask

  task automatic key(input int code);
    step(1'b1, code, cur_sel, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, cur_sel, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, cur_sel, 1'b1);
    step(1'b0, 0, cur_sel, 1'b1);
  endtask

  initial begin
    int pulses, t0, seen;
    bus.KeyValid = 1'b0; bus.KeyCode = '0; bus.ChSel = '0;

    // Reset state and ignored keys in OFF.
    do_reset();
    chk("reset_money", 32'(bus.NumMoney), 32'hFF);
    chk("reset_charging", 32'(bus.Charging), 0);
    key(5); idle(1);
    chk("off_key5_money", 32'(bus.NumMoney), 32'hFF);
    chk("off_key5_time", 32'(bus.NumTime), 32'hFF);

    // Single purchase on channel 0: 15 units -> 30 s.
    cur_sel = 0;
    key(10); key(1); key(5); idle(1);
    chk("entry15_money", 32'(bus.NumMoney), 32'h15);
    chk("entry15_time", 32'(bus.NumTime), 32'h30);
    key(12);
    chk("confirm_charging", 32'(bus.Charging), 32'b01);
    pulses = 0; seen = 0; t0 = tick_total;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      idle(1);
      if (bus.ChDone[0]) begin pulses++; seen = 1; end
    end
    chk("ch0_ticks", tick_total - t0, 30);
    for (int i = 0; i < 3; i++) begin idle(1); if (bus.ChDone[0]) pulses++; end
    chk("ch0_done_pulses", pulses, 1);
    chk("ch0_end_charging", 32'(bus.Charging), 0);
    chk("ch0_end_time", 32'(bus.NumTime), 32'h00);

    // Saturation: 9,9 -> 20; third digit ignored.
    key(10); key(9); key(9); idle(1);
    chk("sat_money", 32'(bus.NumMoney), 32'h20);
    chk("sat_time", 32'(bus.NumTime), 32'h40);
    key(3); idle(1);
    chk("sat3_money", 32'(bus.NumMoney), 32'h20);
    chk("sat3_time", 32'(bus.NumTime), 32'h40);
    key(11); idle(1);

    // Two channels at once, plus a rejected confirm on the busy channel.
    cur_sel = 0; key(1); key(5); key(12);
    cur_sel = 1; key(4); key(12);
    t0 = tick_total;
    chk("dual_charging", 32'(bus.Charging), 32'b11);
    cur_sel = 0; key(1); key(12);
    chk("busy_err", 32'(bus.Err), 1);
    chk("busy_charging", 32'(bus.Charging), 32'b11);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      idle(1);
      if (bus.ChDone[1]) seen = 1;
    end
    chk("ch1_ticks", tick_total - t0, 8);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      idle(1);
      if (bus.ChDone[0]) seen = 1;
    end
    chk("ch0_dual_done", seen, 1);

    // Idle timeout from a fresh READY.
    do_reset();
    key(10); t0 = tick_total; seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      idle(1);
      if (bus.NumMoney == 8'hFF) seen = 1;
    end
    chk("timeout_ticks", tick_total - t0, IDLE_SEC);

    // Timeout held off while channel 1 charges, then 10 s later.
    key(10); cur_sel = 1; key(3); key(12); seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      idle(1);
      if (bus.ChDone[1]) seen = 1;
    end
    chk("hold_ready_money", 32'(bus.NumMoney), 32'h00);
    t0 = tick_total; seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      idle(1);
      if (bus.NumMoney == 8'hFF) seen = 1;
    end
    chk("timeout_after_charge", tick_total - t0, IDLE_SEC);

    // Clear, and confirm with zero money stays in ENTRY.
    cur_sel = 0;
    key(10); key(7); key(11); idle(1);
    chk("clear_money", 32'(bus.NumMoney), 32'h00);
    chk("clear_time", 32'(bus.NumTime), 32'h00);
    key(0); key(12); idle(2);
    chk("zero_confirm_charging", 32'(bus.Charging), 0);
    key(5); idle(1);
    chk("zero_then5_money", 32'(bus.NumMoney), 32'h05);
    chk("zero_then5_time", 32'(bus.NumTime), 32'h10);
    key(11);

    // Random keys against the model.
    for (int i = 0; i < 600; i++) begin
      bit v, r;
      int c;
      v = ($urandom_range(0, 2) == 0);
      c = (($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 15));
      r = ($urandom_range(0, 299) == 0);
      cur_sel = $urandom_range(0, NUM_CH - 1);
      step(v, c, cur_sel, r);
    end

    // Reset in the middle of a charge.
    do_reset();
    cur_sel = 0;
    key(10); key(5); key(12); idle(10);
    step(1'b0, 0, cur_sel, 1'b1);
    chk("midrst_charging", 32'(bus.Charging), 0);
    chk("midrst_done", 32'(bus.ChDone), 0);
    chk("midrst_money", 32'(bus.NumMoney), 32'hFF);
    idle(2);
    chk("midrst_after_done", 32'(bus.ChDone), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
